// File: rtl/div_if.sv
// Handshake and data bundle between the EX stage (master) and the divide sequencer (slave).
// start_i is a request held until ready_o is seen; ready_o qualifies result_o and stays high while start_i is held.
interface div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div_seq.sv
// Multi-cycle radix-2 restoring divider for div/divu: 32 shift-subtract steps, result {remainder, quotient}.
// Sign handling is done on magnitudes; signs are re-applied when the result is loaded.
module div_seq (
  input  logic       clk,
  input  logic       rst,
  div_if.slave       bus,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BYZERO = 2'd1,
    ON     = 2'd2,
    END    = 2'd3
  } state_t;

  state_t      state_q, state_n;
  logic [64:0] dividend_q, dividend_n;
  logic [31:0] divisor_q, divisor_n;
  logic [5:0]  cnt_q, cnt_n;
  logic        sgn_q, sgn_n;
  logic        neg1_q, neg1_n;
  logic        neg2_q, neg2_n;
  logic [63:0] result_q, result_n;
  logic        ready_q, ready_n;

  logic [32:0] diff;
  logic [31:0] abs1, abs2;
  logic [31:0] quo_raw, rem_raw, quo_fix, rem_fix;

  always_comb begin
    diff    = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
    abs1    = (bus.signed_div_i && bus.opdata1_i[31]) ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
    abs2    = (bus.signed_div_i && bus.opdata2_i[31]) ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
    quo_raw = dividend_q[31:0];
    rem_raw = dividend_q[64:33];
    // Quotient sign follows the operand signs; remainder always follows the dividend.
    quo_fix = (sgn_q && (neg1_q ^ neg2_q)) ? (~quo_raw + 32'd1) : quo_raw;
    rem_fix = (sgn_q && neg1_q) ? (~rem_raw + 32'd1) : rem_raw;
  end

  always_comb begin
    state_n    = state_q;
    dividend_n = dividend_q;
    divisor_n  = divisor_q;
    cnt_n      = cnt_q;
    sgn_n      = sgn_q;
    neg1_n     = neg1_q;
    neg2_n     = neg2_q;
    result_n   = result_q;
    ready_n    = ready_q;

    case (state_q)
      FREE: begin
        ready_n  = 1'b0;
        result_n = 64'd0;
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == 32'd0) begin
            state_n = BYZERO;
          end else begin
            state_n    = ON;
            dividend_n = {32'd0, abs1, 1'b0};
            divisor_n  = abs2;
            cnt_n      = 6'd0;
            sgn_n      = bus.signed_div_i;
            neg1_n     = bus.opdata1_i[31];
            neg2_n     = bus.opdata2_i[31];
          end
        end
      end

      BYZERO: begin
        state_n  = END;
        result_n = 64'd0;
        ready_n  = 1'b1;
      end

      ON: begin
        if (bus.annul_i) begin
          state_n    = FREE;
          dividend_n = 65'd0;
          divisor_n  = 32'd0;
          cnt_n      = 6'd0;
          sgn_n      = 1'b0;
          neg1_n     = 1'b0;
          neg2_n     = 1'b0;
          result_n   = 64'd0;
          ready_n    = 1'b0;
        end else if (cnt_q != 6'd32) begin
          if (!diff[32]) dividend_n = {diff[31:0], dividend_q[31:0], 1'b1};
          else           dividend_n = {dividend_q[63:0], 1'b0};
          cnt_n = cnt_q + 6'd1;
        end else begin
          state_n  = END;
          result_n = {rem_fix, quo_fix};
          ready_n  = 1'b1;
        end
      end

      END: begin
        if (!bus.start_i) begin
          state_n  = FREE;
          ready_n  = 1'b0;
          result_n = 64'd0;
        end
      end

      default: state_n = FREE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FREE;
      dividend_q <= 65'd0;
      divisor_q  <= 32'd0;
      cnt_q      <= 6'd0;
      sgn_q      <= 1'b0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      result_q   <= 64'd0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      dividend_q <= dividend_n;
      divisor_q  <= divisor_n;
      cnt_q      <= cnt_n;
      sgn_q      <= sgn_n;
      neg1_q     <= neg1_n;
      neg2_q     <= neg2_n;
      result_q   <= result_n;
      ready_q    <= ready_n;
    end
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: directed corner cases plus randomized operands
// checked against an arithmetic reference model.
module tb_div_seq;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  div_if      dif();

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  div_seq dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (dif.slave),
    .dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain integer division; divide by zero and the signed overflow case are defined results.
  function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (!sgn) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
    sa = a;
    sb = b;
    q  = sa / sb;
    r  = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Full handshake: request, wait for ready, check hold, drop start, check clear.
  task automatic run_div(input string name, input logic sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int lat, want_lat;
    exp = model(sgn, a, b);
    exp_q.push_back(exp);
    want_lat = (b == 32'd0) ? 1 : 33;
    @(negedge clk);
    dif.signed_div_i = sgn;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.start_i      = 1'b1;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      dif.opdata1_i = $urandom;
      dif.opdata2_i = $urandom;
      if (dif.ready_o) break;
    end
    exp = exp_q.pop_front();
    checks++;
    if (!dif.ready_o) begin
      errors++;
      $display("FAIL %s timeout: ready_o=%0b required 1 within 100 cycles", name, dif.ready_o);
    end
    checks++;
    if (dif.result_o !== exp) begin
      errors++;
      $display("FAIL %s result: got %h required %h", name, dif.result_o, exp);
    end
    checks++;
    if (lat - 1 !== want_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d required %0d", name, lat - 1, want_lat);
    end
    @(negedge clk);
    checks++;
    if (dif.ready_o !== 1'b1 || dif.result_o !== exp) begin
      errors++;
      $display("FAIL %s hold: ready=%0b result=%h required 1 %h", name, dif.ready_o, dif.result_o, exp);
    end
    dif.start_i = 1'b0;
    @(negedge clk);
    checks++;
    if (dif.ready_o !== 1'b0 || dif.result_o !== 64'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL %s clear: ready=%0b result=%h state=%0d required 0 0 0", name, dif.ready_o, dif.result_o, dbg_state);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dif.start_i = 1'b0;
    dif.annul_i = 1'b0;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i = 32'd0;
    dif.opdata2_i = 32'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dif.ready_o !== 1'b0 || dif.result_o !== 64'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL reset: ready=%0b result=%h state=%0d required 0 0 0", dif.ready_o, dif.result_o, dbg_state);
    end
  endtask

  task automatic test_directed();
    run_div("udiv_100_7", 1'b0, 32'd100, 32'd7);
    checks++;
    if (model(1'b0, 32'd100, 32'd7) !== 64'h0000_0002_0000_000E) begin
      errors++;
      $display("FAIL model_100_7: got %h required %h", model(1'b0, 32'd100, 32'd7), 64'h0000_0002_0000_000E);
    end
    run_div("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2);
    run_div("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE);
    run_div("sdiv_by0", 1'b1, 32'h1234, 32'd0);
    run_div("udiv_by0", 1'b0, 32'h1234, 32'd0);
    run_div("sdiv_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    run_div("udiv_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1);
  endtask

  task automatic test_start_with_annul();
    @(negedge clk);
    dif.start_i = 1'b1;
    dif.annul_i = 1'b1;
    dif.opdata1_i = 32'd50;
    dif.opdata2_i = 32'd5;
    repeat (3) @(negedge clk);
    checks++;
    if (dbg_state !== 2'd0 || dif.ready_o !== 1'b0) begin
      errors++;
      $display("FAIL start_annul: state=%0d ready=%0b required 0 0", dbg_state, dif.ready_o);
    end
    dif.start_i = 1'b0;
    dif.annul_i = 1'b0;
  endtask

  task automatic test_annul();
    int seen;
    @(negedge clk);
    dif.signed_div_i = 1'b0;
    dif.opdata1_i = 32'd1000;
    dif.opdata2_i = 32'd3;
    dif.start_i = 1'b1;
    repeat (11) @(negedge clk);
    dif.annul_i = 1'b1;
    dif.start_i = 1'b0;
    @(negedge clk);
    dif.annul_i = 1'b0;
    checks++;
    if (dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL annul_state: got %0d required 0", dbg_state);
    end
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (dif.ready_o) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL annul_ready: ready cycles %0d required 0", seen);
    end
    run_div("after_annul_9_3", 1'b0, 32'd9, 32'd3);
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    dif.signed_div_i = 1'b1;
    dif.opdata1_i = 32'hFFFF_0000;
    dif.opdata2_i = 32'd17;
    dif.start_i = 1'b1;
    repeat (15) @(negedge clk);
    rst = 1'b1;
    dif.start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (dif.ready_o !== 1'b0 || dif.result_o !== 64'd0 || dbg_state !== 2'd0) begin
      errors++;
      $display("FAIL mid_reset: ready=%0b result=%h state=%0d required 0 0 0", dif.ready_o, dif.result_o, dbg_state);
    end
    run_div("after_rst_45_6", 1'b0, 32'd45, 32'd6);
  endtask

  task automatic test_random();
    logic        sgn;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = $urandom;
      case ($urandom_range(0, 4))
        0:       b = $urandom;
        1:       b = 32'($urandom_range(1, 15));
        2:       b = ~32'($urandom_range(0, 15));
        3:       b = 32'($urandom_range(0, 2));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      run_div("random", sgn, a, b);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_with_annul();
    test_annul();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
